// File: rtl/pulse_cfg_sequencer_if.sv
// Bundle between the reconfiguration sequencer, the game FSM request side,
// the external iterative divider and the pulse generators.
interface pulse_cfg_sequencer_if;
    // request side (from fsm_game)
    logic        cfg_valid;
    logic [31:0] cfg_freq;
    logic [31:0] cfg_tph;
    logic        cfg_ready;
    // divider side
    logic        div_start;
    logic [31:0] div_num;
    logic [31:0] div_den;
    logic        div_done;
    logic [31:0] div_quot;
    // generator side
    logic        cycle_wrap;
    logic [31:0] period_out;
    logic [31:0] tph_out;
    logic        commit;
    // status
    logic        err;
    logic        clamped;

    // sequencer view
    modport master (
        input  cfg_valid, cfg_freq, cfg_tph, div_done, div_quot, cycle_wrap,
        output cfg_ready, div_start, div_num, div_den,
               period_out, tph_out, commit, err, clamped
    );

    // environment view (requester, divider, generator)
    modport slave (
        output cfg_valid, cfg_freq, cfg_tph, div_done, div_quot, cycle_wrap,
        input  cfg_ready, div_start, div_num, div_den,
               period_out, tph_out, commit, err, clamped
    );
endinterface

// File: rtl/pulse_cfg_sequencer.sv
// Converts a requested frequency into a period via an external divider,
// validates/clamps it, and commits period/tph only on an output cycle wrap
// so the generated waveform never glitches. One-deep pending request slot.
module pulse_cfg_sequencer #(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned PERIOD_MIN     = 20,
    parameter int unsigned DEFAULT_PERIOD = 100_000,
    parameter int unsigned DEFAULT_TPH    = 50_000,
    parameter int unsigned DIV_TIMEOUT    = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    pulse_cfg_sequencer_if.master bus
);
    localparam int unsigned CW = $clog2(DIV_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(DIV_TIMEOUT - 1);
    localparam logic [31:0] NUM  = 32'(CLK_HZ);
    localparam logic [31:0] PMIN = 32'(PERIOD_MIN);
    localparam logic [31:0] DPER = 32'(DEFAULT_PERIOD);
    localparam logic [31:0] DTPH = 32'(DEFAULT_TPH);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_DIV, CHECK, ARM, APPLY
    } state_t;

    state_t         state_q;
    logic [31:0]    freq_q, tph_q, quot_q;
    logic [31:0]    new_tph_q;
    logic           new_clamp_q;
    logic [CW-1:0]  cnt_q;
    logic           pend_vld_q;
    logic [31:0]    pend_freq_q, pend_tph_q;
    logic [31:0]    period_q, tph_out_q;
    logic           commit_q, div_start_q, err_q, clamped_q;

    logic           take_vld;
    logic [31:0]    take_freq, take_tph;
    logic [31:0]    chk_tph;
    logic           chk_clamp;

    // Request source at a dequeue point: a fresh strobe beats the pending slot.
    always_comb begin
        take_vld  = bus.cfg_valid | pend_vld_q;
        take_freq = bus.cfg_valid ? bus.cfg_freq : pend_freq_q;
        take_tph  = bus.cfg_valid ? bus.cfg_tph  : pend_tph_q;
    end

    // High-phase clamp: keep at least one low clock and at least one high clock.
    always_comb begin
        chk_tph   = tph_q;
        chk_clamp = 1'b0;
        if (tph_q >= quot_q) begin
            chk_tph   = quot_q - 32'd1;
            chk_clamp = 1'b1;
        end
        if (tph_q == 32'd0) begin
            chk_tph   = 32'd1;
            chk_clamp = 1'b1;
        end
    end

    // Sequencer FSM with registered outputs and the pending request slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            freq_q      <= '0;
            tph_q       <= '0;
            quot_q      <= '0;
            new_tph_q   <= '0;
            new_clamp_q <= 1'b0;
            cnt_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_freq_q <= '0;
            pend_tph_q  <= '0;
            period_q    <= DPER;
            tph_out_q   <= DTPH;
            commit_q    <= 1'b0;
            div_start_q <= 1'b0;
            err_q       <= 1'b0;
            clamped_q   <= 1'b0;
        end else begin
            commit_q    <= 1'b0;
            div_start_q <= 1'b0;
            // requests arriving mid-flight park in the slot, newest wins
            if (bus.cfg_valid && state_q != IDLE && state_q != APPLY) begin
                pend_vld_q  <= 1'b1;
                pend_freq_q <= bus.cfg_freq;
                pend_tph_q  <= bus.cfg_tph;
            end
            case (state_q)
                IDLE, APPLY: begin
                    pend_vld_q <= 1'b0;
                    state_q    <= IDLE;
                    if (take_vld) begin
                        if (take_freq == 32'd0) begin
                            err_q <= 1'b1;
                        end else begin
                            freq_q      <= take_freq;
                            tph_q       <= take_tph;
                            err_q       <= 1'b0;
                            div_start_q <= 1'b1;
                            state_q     <= START;
                        end
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_DIV;
                end
                WAIT_DIV: begin
                    if (bus.div_done) begin
                        quot_q  <= bus.div_quot;
                        state_q <= CHECK;
                    end else if (cnt_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (quot_q < PMIN) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        new_tph_q   <= chk_tph;
                        new_clamp_q <= chk_clamp;
                        state_q     <= ARM;
                    end
                end
                ARM: begin
                    // wrap is registered here: the update lands the clock after it
                    if (bus.cycle_wrap) begin
                        period_q  <= quot_q;
                        tph_out_q <= new_tph_q;
                        clamped_q <= new_clamp_q;
                        commit_q  <= 1'b1;
                        state_q   <= APPLY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cfg_ready  = (state_q == IDLE) && !pend_vld_q;
    assign bus.div_start  = div_start_q;
    assign bus.div_num    = NUM;
    assign bus.div_den    = freq_q;
    assign bus.period_out = period_q;
    assign bus.tph_out    = tph_out_q;
    assign bus.commit     = commit_q;
    assign bus.err        = err_q;
    assign bus.clamped    = clamped_q;
endmodule

// File: doc/pulse_cfg_sequencer.md
Name: pulse_cfg_sequencer

Overview:
- Sequences reconfiguration of the pulse-generator datapath: the two signal_out instances and the PRBS generator.
- Accepts a requested frequency and high-phase time from the game FSM and drives an external iterative divider to convert frequency to a period in clock cycles.
- Validates and clamps the result, then commits new period and high-phase values only at an output cycle boundary, so the generated waveform never glitches.
- Sits between fsm_game and the pulse generators; replaces direct wiring of pulse_period and tph.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency; divider numerator.
- PERIOD_MIN, 20: smallest legal period in clocks; results below this are rejected.
- DEFAULT_PERIOD, 100_000: period_out after reset (1 kHz).
- DEFAULT_TPH, 50_000: tph_out after reset.
- DIV_TIMEOUT, 63: maximum clocks to wait for div_done before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- cfg_valid  in  1  request strobe, one clock.
- cfg_freq  in  32  requested frequency, Hz, binary.
- cfg_tph  in  32  requested high-phase length, clocks.
- cfg_ready  out  1  high in IDLE with no pending request.
- div_start  out  1  one-clock pulse that launches the divider.
- div_num  out  32  dividend, constant CLK_HZ.
- div_den  out  32  divisor, the latched frequency.
- div_done  in  1  divider result valid, one clock.
- div_quot  in  32  divider quotient.
- cycle_wrap  in  1  one-clock pulse from the generator at the end of each output period.
- period_out  out  32  committed period to the generators.
- tph_out  out  32  committed high phase.
- commit  out  1  one-clock pulse when period_out and tph_out update.
- err  out  1  sticky error flag, cleared by the next accepted request.
- clamped  out  1  sticky flag: last commit reduced tph.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, period_out=DEFAULT_PERIOD, tph_out=DEFAULT_TPH.
  - commit=0, div_start=0, err=0, clamped=0, pending slot empty, cfg_ready=1.
- States: IDLE, START, WAIT_DIV, CHECK, ARM, APPLY.
- IDLE:
  - On cfg_valid, latch freq and tph, clear err, and go to START.
  - If cfg_freq==0, instead set err=1 and stay in IDLE; the divider is not started.
- START: div_start=1 for exactly one clock, with div_den holding the latched freq. Go to WAIT_DIV and clear the timeout counter.
- WAIT_DIV:
  - On div_done, capture div_quot and go to CHECK.
  - If the counter reaches DIV_TIMEOUT without div_done, set err=1 and go to IDLE. Outputs are unchanged.
- CHECK, one clock:
  - If quot < PERIOD_MIN, set err=1 and go to IDLE.
  - If tph >= quot, set new tph = quot-1 and clamped=1; otherwise clamped=0.
  - If tph==0, set new tph = 1 and clamped=1.
  - Go to ARM.
- ARM: wait for cycle_wrap. There is no timeout, because the generator always wraps.
- APPLY:
  - Entered on the clock after cycle_wrap is seen in ARM. The cycle_wrap is registered, giving 1-clock latency.
  - period_out and tph_out update together, and commit=1 for one clock.
  - Go to IDLE, or to START if the pending slot is full.
- Request while busy (cfg_valid outside IDLE):
  - Stored in a one-deep pending slot; the newest request overwrites the older one.
  - The in-flight request always completes first.
  - freq==0 in the pending slot is detected when it is dequeued, with the same handling as in IDLE.
- cfg_valid and a dequeue in the same clock: the new request takes the slot; the old pending entry is discarded.
- Reset mid-operation: all state is discarded and outputs return to defaults immediately. A divider result arriving after reset is ignored, since the state is IDLE.
- div_done outside WAIT_DIV is ignored.
- Width rules: all arithmetic is 32-bit unsigned. The comparison tph >= quot is unsigned, and quot-1 cannot underflow because quot >= PERIOD_MIN.
- Latency with the divider responding in D clocks and the next cycle_wrap W clocks after CHECK: cfg_valid to commit = 1 + 1 + D + 1 + W + 1 clocks.

Test Plan:
- Reset release → period_out=100000, tph_out=50000, cfg_ready=1, err=0.
- cfg_freq=2000, cfg_tph=10000, divider model returns 50000 after 32 clocks, cycle_wrap 100 clocks later → exactly one div_start with div_den=2000, commit one clock after cycle_wrap, period_out=50000, tph_out=10000, clamped=0.
- cfg_freq=10_000_000, quot=10 → err=1, no commit, outputs unchanged.
- cfg_freq=5000, cfg_tph=30000, quot=20000 → commit with tph_out=19999 and clamped=1.
- Divider never asserts div_done → err=1 at clock 63 of WAIT_DIV, state back to IDLE. A following valid request completes normally.
- Three requests while in ARM (freq 1000, 2000, 4000) → the first commit is the in-flight value, then exactly one further commit with period_out=25000. Assert reset in WAIT_DIV → outputs at defaults, and a late div_done produces no commit.
